// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch front end.
//   INST_ADDR_WIDTH : byte-address width of instruction memory (`INST_ADDR_WIDTH)
//   FETCH_WIDTH     : instructions per fetch bundle (`FETCH_WIDTH)
//   BUNDLE_BYTES    : byte stride between consecutive bundles
//   fetch_bundle_t  : one queue entry, {pc, inst[FETCH_WIDTH]}
//   fetch_state_t   : sequencer state
// -----------------------------------------------------------------------------
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

package fetch_pkg;

    localparam int unsigned INST_ADDR_WIDTH = `INST_ADDR_WIDTH;
    localparam int unsigned FETCH_WIDTH     = `FETCH_WIDTH;
    localparam int unsigned BUNDLE_BYTES    = 4 * FETCH_WIDTH;

    typedef logic [FETCH_WIDTH-1:0][31:0] inst_bundle_t;

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] pc;
        inst_bundle_t               inst;
    } fetch_bundle_t;

    typedef enum logic {
        INIT,
        RUN
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the instruction-memory, redirect and decode-side signals of the
// fetch sequencer.
//   master : the fetch sequencer (drives pc, out_*, fq_count)
//   slave  : the environment (drives inst_in, redirect_*, out_ready)
// Parameter FQ_DEPTH sizes fq_count and must match the sequencer.
// -----------------------------------------------------------------------------
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = 4
);
    logic [INST_ADDR_WIDTH-1:0]    pc;
    inst_bundle_t                  inst_in;
    logic                          redirect_valid;
    logic [INST_ADDR_WIDTH-1:0]    redirect_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [INST_ADDR_WIDTH-1:0]    out_pc;
    inst_bundle_t                  out_inst;
    logic [$clog2(FQ_DEPTH):0]     fq_count;

    modport master (
        output pc,
        input  inst_in,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output fq_count
    );

    modport slave (
        input  pc,
        output inst_in,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  fq_count
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular FIFO of T entries. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push     : write i_data at tail (caller guarantees !o_full || i_pop)
//   i_pop      : advance head (caller guarantees !o_empty)
//   i_flush    : drop all entries; overrides push and pop
//   o_data     : head entry
//   o_count    : occupied entries
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_bundle_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  T                       i_data,
    output T                       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int unsigned IW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [IW:0]  r_wr_ptr;
    logic [IW:0]  r_rd_ptr;
    logic [IW:0]  w_wr_ptr_next;
    logic [IW:0]  w_rd_ptr_next;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (i_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (i_push) w_wr_ptr_next = r_wr_ptr + 1'b1;
            if (i_pop)  w_rd_ptr_next = r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Storage is intentionally not reset. When full, tail and head share a
    // slot; a simultaneous push overwrites the entry being popped, which is safe.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[IW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[IW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == (IW+1)'(DEPTH));
    assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Drives the instruction-memory PC, captures each returned bundle into the
// fetch queue and presents the queue head to decode via valid/ready.
// A redirect flushes the queue and restarts fetch at the new PC.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_bus       : fetch_if master (pc, inst_in, redirect_*, out_*, fq_count)
// Parameters: FQ_DEPTH (power of two, >= 2), RESET_PC (4-byte aligned).
// Address and fetch widths come from fetch_pkg.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned                FQ_DEPTH = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  fetch_bus
);
    fetch_state_t               r_state;
    fetch_state_t               w_state_next;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic [INST_ADDR_WIDTH-1:0] w_pc_next;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(FQ_DEPTH):0]  w_count;
    fetch_bundle_t              w_wr_bundle;
    fetch_bundle_t              w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            INIT:    w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = INIT;
        endcase

        // Redirect outranks both queue ports; a full queue may still accept a
        // push in the same cycle it pops.
        w_pop  = !w_empty && fetch_bus.out_ready && !fetch_bus.redirect_valid;
        w_push = (r_state == RUN) && !fetch_bus.redirect_valid && (!w_full || w_pop);

        w_pc_next = r_pc;
        if (fetch_bus.redirect_valid) begin
            w_pc_next = {fetch_bus.redirect_pc[INST_ADDR_WIDTH-1:2], 2'b00};
        end else if (w_push) begin
            w_pc_next = r_pc + INST_ADDR_WIDTH'(BUNDLE_BYTES);
        end
    end

    assign w_wr_bundle.pc   = r_pc;
    assign w_wr_bundle.inst = fetch_bus.inst_in;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (fetch_bundle_t)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (fetch_bus.redirect_valid),
        .i_data  (w_wr_bundle),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fetch_bus.pc        = r_pc;
    assign fetch_bus.out_valid = !w_empty;
    assign fetch_bus.out_pc    = w_head.pc;
    assign fetch_bus.out_inst  = w_head.inst;
    assign fetch_bus.fq_count  = w_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer (FETCH_WIDTH=2, FQ_DEPTH=4, RESET_PC=0).
// The instruction memory is a combinational function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fetch_if #(.FQ_DEPTH(4)) bus ();

    fetch_sequencer #(
        .FQ_DEPTH (4),
        .RESET_PC ('0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A00_0001;
    endfunction

    function automatic logic [63:0] exp_inst(input logic [31:0] p);
        return {mem_word(p + 32'd4), mem_word(p)};
    endfunction

    assign bus.inst_in = exp_inst(bus.pc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.fq_count), 64'd0);
        check("rst_pc",    64'(bus.pc),       64'd0);
        rst_n = 1'b1;

        // E0: INIT -> RUN, nothing pushed yet
        step();
        check("e0_valid", 64'(bus.out_valid), 64'd0);
        check("e0_pc",    64'(bus.pc),        64'd0);
        // E1: bundle at 0 visible
        step();
        check("e1_valid", 64'(bus.out_valid), 64'd1);
        check("e1_outpc", 64'(bus.out_pc),    64'h0);
        check("e1_inst",  64'(bus.out_inst),  exp_inst(32'h0));
        check("e1_pc",    64'(bus.pc),        64'h8);
        step();
        check("s2_outpc", 64'(bus.out_pc),    64'h8);
        check("s2_inst",  64'(bus.out_inst),  exp_inst(32'h8));
        check("s2_count", 64'(bus.fq_count),  64'd1);
        step();
        check("s3_outpc", 64'(bus.out_pc),    64'h10);

        // Back-pressure: fill from 0 with out_ready low
        bus.out_ready = 1'b0;
        redirect_to(32'h0);
        check("bp_count0", 64'(bus.fq_count), 64'd0);
        step();
        check("bp_count1", 64'(bus.fq_count), 64'd1);
        step();
        check("bp_count2", 64'(bus.fq_count), 64'd2);
        step();
        check("bp_count3", 64'(bus.fq_count), 64'd3);
        step();
        check("bp_count4", 64'(bus.fq_count), 64'd4);
        check("bp_pc4",    64'(bus.pc),       64'h20);
        step();
        check("bp_sat_cnt", 64'(bus.fq_count), 64'd4);
        check("bp_sat_pc",  64'(bus.pc),       64'h20);
        check("bp_head",    64'(bus.out_pc),   64'h0);
        check("bp_head_in", 64'(bus.out_inst), exp_inst(32'h0));

        // Full with pop in the same cycle
        bus.out_ready = 1'b1;
        step();
        check("fp_count", 64'(bus.fq_count), 64'd4);
        check("fp_pc",    64'(bus.pc),       64'h28);
        check("fp_outpc", 64'(bus.out_pc),   64'h8);
        step();
        check("dr_outpc10", 64'(bus.out_pc), 64'h10);
        step();
        check("dr_outpc18", 64'(bus.out_pc), 64'h18);
        step();
        check("dr_outpc20", 64'(bus.out_pc),   64'h20);
        check("dr_inst20",  64'(bus.out_inst), exp_inst(32'h20));
        step();
        check("dr_outpc28", 64'(bus.out_pc), 64'h28);

        // Redirect with 3 bundles queued
        bus.out_ready = 1'b0;
        redirect_to(32'h40);
        step();
        step();
        step();
        check("rd_pre_cnt", 64'(bus.fq_count), 64'd3);
        redirect_to(32'h103);
        check("rd_valid", 64'(bus.out_valid), 64'd0);
        check("rd_count", 64'(bus.fq_count),  64'd0);
        check("rd_pc",    64'(bus.pc),        64'h100);
        step();
        check("rd_valid1", 64'(bus.out_valid), 64'd1);
        check("rd_outpc",  64'(bus.out_pc),    64'h100);
        check("rd_inst",   64'(bus.out_inst),  exp_inst(32'h100));

        // Address wrap-around
        bus.out_ready = 1'b1;
        redirect_to(32'hFFFF_FFF8);
        check("wr_pc", 64'(bus.pc), 64'hFFFF_FFF8);
        step();
        check("wr_outpc_top", 64'(bus.out_pc), 64'hFFFF_FFF8);
        check("wr_pc0",       64'(bus.pc),     64'h0);
        step();
        check("wr_outpc0", 64'(bus.out_pc),   64'h0);
        check("wr_inst0",  64'(bus.out_inst), exp_inst(32'h0));

        // Asynchronous reset with 2 bundles queued
        bus.out_ready = 1'b0;
        redirect_to(32'h200);
        step();
        step();
        check("ar_pre_cnt", 64'(bus.fq_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_count", 64'(bus.fq_count),  64'd0);
        check("ar_pc",    64'(bus.pc),        64'h0);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        check("ar_e0_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("ar_e1_valid", 64'(bus.out_valid), 64'd1);
        check("ar_e1_outpc", 64'(bus.out_pc),    64'h0);
        check("ar_e1_pc",    64'(bus.pc),        64'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end fetch controller that drives the instruction-memory PC and buffers fetched bundles for decode. Each cycle it presents a PC to the combinational instruction memory and captures the FETCH_WIDTH returned words, together with their PC, into a small circular fetch queue. Decode drains the queue through a valid/ready handshake. A redirect from the back end flushes the queue and restarts fetch at a new PC.

## Interface
- INST_ADDR_WIDTH, default `INST_ADDR_WIDTH: byte-address width of instruction memory
- FETCH_WIDTH, default `FETCH_WIDTH: instructions per bundle
- FQ_DEPTH, default 4: fetch-queue entries, in bundles; power of two, ≥2
- RESET_PC, default 0: first fetch address; must be 4-byte aligned
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- pc  out  INST_ADDR_WIDTH  fetch address to instruction memory
- inst_in  in  32 x FETCH_WIDTH  words returned combinationally for pc
- redirect_valid  in  1  flush and restart request
- redirect_pc  in  INST_ADDR_WIDTH  restart address; bits [1:0] are ignored and forced to 0
- out_valid  out  1  head bundle valid
- out_ready  in  1  decode accepts head bundle
- out_pc  out  INST_ADDR_WIDTH  PC of head bundle
- out_inst  out  32 x FETCH_WIDTH  head bundle instructions
- fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries

## Operation
- States:
  - INIT: one cycle after reset deasserts, so the memory image can load during reset. Always moves to RUN.
  - RUN: steady-state fetching.
- push = RUN && !redirect_valid && (fq_count < FQ_DEPTH || pop).
- pop = out_valid && out_ready && !redirect_valid.
- On push:
  - Write {pc, inst_in} at the tail.
  - pc <= pc + 4*FETCH_WIDTH, modulo 2^INST_ADDR_WIDTH; wrap-around is silent.
- If the queue is full and there is no pop:
  - pc holds.
  - No write.
  - inst_in is ignored.
- Push and pop in the same cycle are legal at any occupancy, including full. Occupancy is unchanged.
- Pop on an empty queue cannot occur, because out_valid is 0.
- Redirect has priority over push and pop:
  - Head, tail and count are reset to 0.
  - pc <= {redirect_pc[W-1:2], 2'b00}.
  - The bundle presented that cycle is discarded.
  - A redirect arriving in INIT is applied to pc. The state still moves to RUN.
- out_valid = (fq_count != 0). out_pc and out_inst come from the head entry. Contents are don't-care when out_valid = 0.
- Once out_valid is asserted, the head entry must hold stable until popped or flushed.
- Reset values:
  - state = INIT
  - pc = RESET_PC
  - head = tail = 0
  - fq_count = 0
  - out_valid = 0
  - Queue storage is not reset.
- Reset asserted mid-operation:
  - All of the above apply immediately and asynchronously.
  - Queued bundles are lost.

## Timing
- Edge E0: first rising edge with reset high. INIT → RUN.
- Edge E1: bundle at RESET_PC is pushed. After E1, out_valid = 1 and out_pc = RESET_PC.
- Fetch-to-output latency is 1 edge. Steady-state throughput is 1 bundle per cycle when out_ready is held high.
- Redirect sampled at edge N:
  - After N, out_valid = 0 and pc = redirect_pc.
  - After N+1, out_valid = 1 and out_pc = redirect_pc.
- fq_count and out_valid are registered. Nothing depends combinationally on out_ready except the internal push enable.

## Structure
- The shared package fetch_pkg holds:
  - fetch_bundle_t: struct {pc, inst[FETCH_WIDTH]}.
  - fetch_state_t: enum {INIT, RUN}.
  - The constant BUNDLE_BYTES = 4*FETCH_WIDTH.
- Sub-module fetch_queue: a generic circular FIFO of fetch_bundle_t with push, pop, flush, count, full and empty.
  - The pointers carry one wrap bit.
- fetch_sequencer holds the PC register, the state machine and the push/pop/redirect arbitration.

## Test plan
- Reset release, FETCH_WIDTH=2, RESET_PC=0x0, out_ready=1 → out_pc sequence 0x0, 0x8, 0x10, … one per cycle. Instructions match the memory image.
- out_ready=0, FQ_DEPTH=4 → fq_count saturates at 4 and pc holds at 0x20. Raising out_ready resumes with out_pc 0x0 and no bundle lost or duplicated.
- Queue full with out_ready=1 in the same cycle → fq_count stays at 4 and pc advances by 8.
- redirect_valid with redirect_pc=0x103 while 3 bundles are queued → next cycle out_valid=0 and fq_count=0. The following cycle out_pc=0x100.
- INST_ADDR_WIDTH=8 with the PC starting at 0xF8 → the next out_pc is 0x00 (wrap).
- reset asserted while the queue holds 2 bundles → out_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge. Restart repeats the E0/E1 timing.
